// File: rtl/scan_8seg_pkg.sv
// Shared constants for the multiplexed 8-segment scanner: segment font,
// counter widths and a width helper.
package scan_8seg_pkg;

  typedef logic [6:0] seg7_t;

  localparam int NIB_W = 4;
  localparam int PWM_W = 4;

  // Bit order {g,f,e,d,c,b,a}; entry 0 is the rightmost element of the literal.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Counter width for a modulus, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_SLOT_W = cnt_w(1024);
  localparam int DEF_IDX_W  = cnt_w(4);

endpackage

// File: rtl/seg7_font.sv
// Combinational hex nibble to 7-segment pattern; no dot, no enable.
module seg7_font
  import scan_8seg_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output seg7_t            seg
);

  assign seg = SEG_FONT[nib];

endmodule

// File: rtl/scan_8seg.sv
// Time-multiplexed driver for a bank of 8-segment displays with PWM
// brightness, dead-time between digits and leading-zero suppression.
module scan_8seg
  import scan_8seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SLOT_CYCLES    = 1024,
  parameter int DEAD_CYCLES    = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    oe,
  input  logic                    load,
  input  logic [NIB_W*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]       dots,
  input  logic                    blank_lz,
  input  logic [3:0]              brightness,
  output logic [7:0]              leds,
  output logic [DIGITS-1:0]       digit_en,
  output logic                    frame
);

  localparam int SLOT_W = cnt_w(SLOT_CYCLES);
  localparam int IDX_W  = cnt_w(DIGITS);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] DEAD_END  = SLOT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [NIB_W*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]       shadow_dots_q, shadow_dots_d;
  logic [NIB_W*DIGITS-1:0] disp_val_q, disp_val_d;
  logic [DIGITS-1:0]       disp_dots_q, disp_dots_d;
  logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PWM_W-1:0]        pwm_cnt_q, pwm_cnt_d;
  logic [7:0]              leds_q, leds_d;
  logic [DIGITS-1:0]       digit_en_q, digit_en_d;
  logic                    frame_q, frame_d;

  logic                    slot_end;
  logic                    idx_wrap;
  logic [NIB_W-1:0]        cur_nib;
  logic                    cur_dot;
  logic [DIGITS-1:0]       cur_onehot;
  logic                    upper_zero;
  logic                    cur_upper_zero;
  logic                    lz_blank;
  logic                    lit;
  seg7_t                   font_seg;

  // The display copy only refreshes as a new slot begins, so a load never
  // disturbs the digit currently on the pins; a load on that same edge wins.
  always_comb begin
    slot_end      = (slot_cnt_q == SLOT_LAST);
    idx_wrap      = slot_end && (idx_q == IDX_LAST);
    shadow_val_d  = load ? value : shadow_val_q;
    shadow_dots_d = load ? dots  : shadow_dots_q;
    disp_val_d    = slot_end ? shadow_val_d  : disp_val_q;
    disp_dots_d   = slot_end ? shadow_dots_d : disp_dots_q;
    slot_cnt_d    = slot_end ? '0 : slot_cnt_q + 1'b1;
    idx_d         = idx_q;
    if (slot_end) begin
      idx_d = idx_wrap ? '0 : idx_q + 1'b1;
    end
    pwm_cnt_d     = pwm_cnt_q + 1'b1;
  end

  // Walk from the most significant digit down so upper_zero means
  // "this digit and every digit above it is zero".
  always_comb begin
    cur_nib        = '0;
    cur_dot        = 1'b0;
    cur_onehot     = '0;
    upper_zero     = 1'b1;
    cur_upper_zero = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp_val_q[NIB_W*i +: NIB_W] == '0);
      if (idx_q == IDX_W'(i)) begin
        cur_nib        = disp_val_q[NIB_W*i +: NIB_W];
        cur_dot        = disp_dots_q[i];
        cur_onehot[i]  = 1'b1;
        cur_upper_zero = upper_zero;
      end
    end
  end

  seg7_font u_font (
    .nib (cur_nib),
    .seg (font_seg)
  );

  always_comb begin
    lz_blank   = blank_lz && (idx_q != '0) && cur_upper_zero;
    lit        = (slot_cnt_q >= DEAD_END) && (pwm_cnt_q <= brightness) && oe;
    leds_d     = '0;
    digit_en_d = '0;
    if (lit) begin
      leds_d     = {cur_dot, lz_blank ? 7'h00 : font_seg};
      digit_en_d = cur_onehot;
    end
    frame_d    = idx_wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val_q  <= '0;
      shadow_dots_q <= '0;
      disp_val_q    <= '0;
      disp_dots_q   <= '0;
      slot_cnt_q    <= '0;
      idx_q         <= '0;
      pwm_cnt_q     <= '0;
      leds_q        <= '0;
      digit_en_q    <= '0;
      frame_q       <= 1'b0;
    end else begin
      shadow_val_q  <= shadow_val_d;
      shadow_dots_q <= shadow_dots_d;
      disp_val_q    <= disp_val_d;
      disp_dots_q   <= disp_dots_d;
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      pwm_cnt_q     <= pwm_cnt_d;
      leds_q        <= leds_d;
      digit_en_q    <= digit_en_d;
      frame_q       <= frame_d;
    end
  end

  // Pin polarity is applied after the register so reset drives the idle level.
  assign leds     = leds_q ^ {8{SEG_ACTIVE_LOW}};
  assign digit_en = digit_en_q ^ {DIGITS{DIG_ACTIVE_LOW}};
  assign frame    = frame_q;

endmodule

// File: tb/tb_scan_8seg.sv
// Randomized and directed bench for scan_8seg against a time-based model.
module tb_scan_8seg;

  localparam int DIG  = 4;
  localparam int SLOT = 32;
  localparam int DEAD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            oe = 1'b1;
  logic            load = 1'b0;
  logic [4*DIG-1:0] value = '0;
  logic [DIG-1:0]  dots = '0;
  logic            blank_lz = 1'b0;
  logic [3:0]      brightness = 4'hF;

  logic [7:0]      leds, leds_n;
  logic [DIG-1:0]  digit_en, digit_en_n;
  logic            frame, frame_n;

  int total = 0;
  int bad   = 0;

  scan_8seg #(.DIGITS(DIG), .SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD),
              .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst(rst), .oe(oe), .load(load), .value(value), .dots(dots),
    .blank_lz(blank_lz), .brightness(brightness),
    .leds(leds), .digit_en(digit_en), .frame(frame));

  scan_8seg #(.DIGITS(DIG), .SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD),
              .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut_n (
    .clk(clk), .rst(rst), .oe(oe), .load(load), .value(value), .dots(dots),
    .blank_lz(blank_lz), .brightness(brightness),
    .leds(leds_n), .digit_en(digit_en_n), .frame(frame_n));

  always #5 clk = ~clk;

  // Reference model: everything is derived from the number of clocks since reset.
  logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          m_n = 0;
  int          m_slot, m_idx;
  logic        m_lit;
  logic [15:0] m_up;
  logic [15:0] m_shadow = '0, m_disp = '0;
  logic [3:0]  m_sdots = '0, m_ddots = '0;
  logic [7:0]  m_leds = '0;
  logic [3:0]  m_dig = '0;
  logic        m_frame = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_n = 0; m_shadow = '0; m_sdots = '0; m_disp = '0; m_ddots = '0;
      m_leds = '0; m_dig = '0; m_frame = 1'b0;
    end else begin
      m_slot = m_n % SLOT;
      m_idx  = (m_n / SLOT) % DIG;
      m_lit  = (m_slot >= DEAD) && ((m_n % 16) <= int'(brightness)) && (oe == 1'b1);
      m_up   = m_disp >> (4 * m_idx);
      if (m_lit) begin
        m_leds = {m_ddots[m_idx],
                  (blank_lz && m_idx != 0 && m_up == 16'h0) ? 7'h00 : font_tab[m_up[3:0]]};
        m_dig  = 4'(1 << m_idx);
      end else begin
        m_leds = 8'h00;
        m_dig  = 4'h0;
      end
      m_frame = (m_slot == SLOT - 1) && (m_idx == DIG - 1);
      if (load) begin
        m_shadow = value;
        m_sdots  = dots;
      end
      m_n = m_n + 1;
      if (m_n % SLOT == 0) begin
        m_disp  = m_shadow;
        m_ddots = m_sdots;
      end
    end
  end

  function automatic logic [25:0] got();
    return {leds, digit_en, frame, leds_n, digit_en_n, frame_n};
  endfunction

  function automatic logic [25:0] want();
    return {m_leds, m_dig, m_frame, ~m_leds, ~m_dig, m_frame};
  endfunction

  task automatic start_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dots = d;
  endtask

  task automatic wait_phase(input int modulus, input int r);
    for (int k = 0; k < 4 * modulus && (m_n % modulus) != r; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_load(16'h1234, 4'h0);
    repeat (2) @(negedge clk);
    load = 1'b0;
    total++;
    if (got() !== {8'h00, 4'h0, 1'b0, 8'hFF, 4'hF, 1'b0}) begin
      bad++; $display("FAIL reset_idle got=%h want=%h", got(), {8'h00, 4'h0, 1'b0, 8'hFF, 4'hF, 1'b0});
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (digit_en !== 4'h0 || leds !== 8'h00) begin
        bad++; $display("FAIL reset_dead cyc=%0d got=%h/%h want=0/00", c, digit_en, leds);
      end
    end
    @(negedge clk);
    total++;
    if (digit_en !== 4'b0001 || leds !== 8'h3F) begin
      bad++; $display("FAIL reset_first_lit got=%h/%h want=1/3f", digit_en, leds);
    end
    repeat (60) begin
      @(negedge clk);
      total++;
      if (got() !== want()) begin bad++; $display("FAIL reset_scan got=%h want=%h", got(), want()); end
    end
  endtask

  task automatic test_scan();
    int frames = 0;
    brightness = 4'hF; oe = 1'b1; blank_lz = 1'b0;
    start_load(16'h1234, 4'b0101);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (c < 256 && frame === 1'b1) frames++;
      total++;
      if (got() !== want()) begin bad++; $display("FAIL scan got=%h want=%h", got(), want()); end
    end
    total++;
    if (frames != 2) begin bad++; $display("FAIL frame_rate got=%0d want=2", frames); end
  endtask

  task automatic test_blank();
    logic [7:0] seen [DIG];
    logic [15:0] vals [3] = '{16'h0007, 16'h0007, 16'h0000};
    logic [3:0]  dts  [3] = '{4'b0010, 4'b0010, 4'b0000};
    logic        bl   [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0]  exp  [3][DIG] = '{'{8'h07, 8'h80, 8'h00, 8'h00},
                                   '{8'h07, 8'hBF, 8'h3F, 8'h3F},
                                   '{8'h3F, 8'h00, 8'h00, 8'h00}};
    brightness = 4'hF; oe = 1'b1;
    for (int s = 0; s < 3; s++) begin
      blank_lz = bl[s];
      start_load(vals[s], dts[s]);
      for (int d = 0; d < DIG; d++) seen[d] = 8'hEE;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        load = 1'b0;
        if (c >= 160)
          for (int d = 0; d < DIG; d++) if (digit_en[d] === 1'b1) seen[d] = leds;
        total++;
        if (got() !== want()) begin bad++; $display("FAIL blank_scan s=%0d got=%h want=%h", s, got(), want()); end
      end
      for (int d = 0; d < DIG; d++) begin
        total++;
        if (seen[d] !== exp[s][d]) begin
          bad++; $display("FAIL blank_digit s=%0d d=%0d got=%h want=%h", s, d, seen[d], exp[s][d]);
        end
      end
    end
  endtask

  task automatic test_brightness();
    int lit_cnt;
    logic [3:0] lv [2] = '{4'd3, 4'd15};
    int         le [2] = '{16, 112};
    oe = 1'b1; blank_lz = 1'b0;
    for (int s = 0; s < 2; s++) begin
      brightness = lv[s];
      lit_cnt = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (c < 128 && digit_en !== 4'h0) lit_cnt++;
        total++;
        if (got() !== want()) begin bad++; $display("FAIL bright_scan got=%h want=%h", got(), want()); end
      end
      total++;
      if (lit_cnt != le[s]) begin bad++; $display("FAIL bright_duty b=%0d got=%0d want=%0d", lv[s], lit_cnt, le[s]); end
    end
    for (int s = 0; s < 8; s++) begin
      brightness = 4'($urandom_range(0, 15));
      repeat (40) begin
        @(negedge clk);
        total++;
        if (got() !== want()) begin bad++; $display("FAIL bright_rand got=%h want=%h", got(), want()); end
      end
    end
  endtask

  task automatic test_midslot_load();
    logic [7:0] early0 = 8'hEE;
    logic [7:0] late0 = 8'hEE;
    brightness = 4'hF; oe = 1'b1; blank_lz = 1'b0;
    start_load(16'h1234, 4'h0);
    @(negedge clk);
    load = 1'b0;
    wait_phase(128, 10);
    start_load(16'hABCD, 4'h0);
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (digit_en[0] === 1'b1) begin
        if (c < 22) early0 = leds; else late0 = leds;
      end
      total++;
      if (got() !== want()) begin bad++; $display("FAIL midload_scan got=%h want=%h", got(), want()); end
    end
    total++;
    if (early0 !== 8'h66) begin bad++; $display("FAIL midload_hold got=%h want=66", early0); end
    total++;
    if (late0 !== 8'h5E) begin bad++; $display("FAIL midload_new got=%h want=5e", late0); end
    wait_phase(SLOT, SLOT - 1);
    start_load(16'h5678, 4'b1000);
    repeat (80) begin
      @(negedge clk);
      load = 1'b0;
      total++;
      if (got() !== want()) begin bad++; $display("FAIL edge_load got=%h want=%h", got(), want()); end
    end
  endtask

  task automatic test_oe();
    int frames = 0;
    oe = 1'b0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (c >= 1 && frame === 1'b1) frames++;
      total++;
      if (got() !== want()) begin bad++; $display("FAIL oe_off got=%h want=%h", got(), want()); end
    end
    total++;
    if (frames != 2) begin bad++; $display("FAIL oe_frame got=%0d want=2", frames); end
    repeat (300) begin
      oe = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (got() !== want()) begin bad++; $display("FAIL oe_toggle got=%h want=%h", got(), want()); end
    end
    oe = 1'b1;
  endtask

  task automatic test_reset_mid();
    brightness = 4'hF; oe = 1'b1;
    wait_phase(SLOT, 17);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (got() !== {8'h00, 4'h0, 1'b0, 8'hFF, 4'hF, 1'b0}) begin
      bad++; $display("FAIL reset_mid got=%h want=%h", got(), {8'h00, 4'h0, 1'b0, 8'hFF, 4'hF, 1'b0});
    end
    repeat (200) begin
      @(negedge clk);
      total++;
      if (got() !== want()) begin bad++; $display("FAIL reset_mid_scan got=%h want=%h", got(), want()); end
    end
  endtask

  task automatic test_random();
    repeat (3000) begin
      load = ($urandom_range(0, 19) == 0);
      if (load) begin value = 16'($urandom); dots = 4'($urandom); end
      if ($urandom_range(0, 49) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 29) == 0) brightness = 4'($urandom);
      oe  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      total++;
      if (got() !== want()) begin bad++; $display("FAIL random got=%h want=%h", got(), want()); end
    end
    rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blank();
    test_brightness();
    test_midslot_load();
    test_oe();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
